// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: packs MIPS R/I/J field tuples into 32-bit instruction words,
// queues them in a small FIFO and presents each with a sequential byte address
// for writing into instruction memory.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid / in_ready   field tuple handshake (in_ready depends on registered occupancy only)
//   in_fmt                0=R, 1=I, 2=J, 3=reserved (accepted, dropped, sets err)
//   in_opcode .. in_jmp_target  instruction fields
//   out_valid / out_ready head-of-FIFO handshake
//   out_inst, out_addr    encoded word at the head and its byte address
//   count                 FIFO occupancy
//   err                   sticky flag: an illegal tuple was dropped (cleared only by rst)
//
// Optional build macro INST_ENC_CHECK_EN: when defined, R tuples with a non-zero
// opcode and J tuples whose opcode is not 2 or 3 are also treated as illegal.
module inst_encoder_loader #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_fmt,
    input  logic [5:0]               in_opcode,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_shamt,
    input  logic [5:0]               in_funct,
    input  logic [15:0]              in_imm16,
    input  logic [25:0]              in_jmp_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]       r_mem [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic              w_acc;
    logic              w_pop;
    logic              w_push;
    logic              w_illegal;
    logic [31:0]       w_inst;

    assign in_ready  = r_count != CW'(DEPTH);
    assign out_valid = r_count != '0;
    assign out_inst  = out_valid ? r_mem[r_rd] : 32'h0;
    assign out_addr  = r_addr;
    assign count     = r_count;
    assign err       = r_err;

    assign w_acc  = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;
    assign w_push = w_acc && !w_illegal;

`ifdef INST_ENC_CHECK_EN
    assign w_illegal = (in_fmt == 2'd3) ||
                       (in_fmt == 2'd0 && in_opcode != 6'd0) ||
                       (in_fmt == 2'd2 && in_opcode != 6'd2 && in_opcode != 6'd3);
`else
    assign w_illegal = in_fmt == 2'd3;
`endif

    always_comb begin
        w_inst = in_fmt == 2'd0 ? {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct} :
                 in_fmt == 2'd1 ? {in_opcode, in_rs, in_rt, in_imm16} :
                                  {in_opcode, in_jmp_target};
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push && !rst)
            r_mem[r_wr] <= w_inst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_addr  <= BASE_ADDR;
            r_err   <= 1'b0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_addr <= r_addr + ADDR_W'(4);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_acc && w_illegal)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader: scoreboard bench; a reference model queues expected
// words on every accepted tuple and a negedge monitor compares the DUT head.
module tb_inst_encoder_loader;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;
    localparam logic [ADDR_W-1:0] BASE = 4'h0;

    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0, in_ready, out_valid, out_ready = 0, err;
    logic [1:0] in_fmt = 0;
    logic [5:0] in_opcode = 0, in_funct = 0;
    logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
    logic [15:0] in_imm16 = 0;
    logic [25:0] in_jmp_target = 0;
    logic [31:0] out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_bad = 0;

    inst_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
        .in_imm16(in_imm16), .in_jmp_target(in_jmp_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_enc(input int unsigned fmt, op, rs, rt, rd, sh, fn, imm, tgt);
        int unsigned v;
        if (fmt == 0)      v = op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
        else if (fmt == 1) v = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
        else               v = op * 67108864 + tgt;
        return v;
    endfunction

    function automatic bit model_legal(input int unsigned fmt, op);
        bit ok;
        ok = fmt != 3;
`ifdef INST_ENC_CHECK_EN
        if (fmt == 0 && op != 0) ok = 0;
        if (fmt == 2 && op != 2 && op != 3) ok = 0;
`endif
        return ok;
    endfunction

    // Reference model: queue of pending words, head address, sticky error.
    logic [31:0] q[$];
    int unsigned m_addr = 0;
    bit m_err = 0;
    bit armed = 0;

    always @(negedge clk) begin
        bit pop, acc;
        if (armed) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
            chk("err", 32'(err), 32'(m_err));
            chk("out_addr", 32'(out_addr), m_addr);
            if (q.size() != 0) chk("out_inst", out_inst, q[0]);
        end
        if (rst) begin
            q.delete();
            m_addr = 32'(BASE);
            m_err = 0;
            armed = 1;
        end else if (armed) begin
            pop = out_ready && q.size() != 0;
            acc = in_valid && q.size() != DEPTH;
            if (pop) begin
                void'(q.pop_front());
                m_addr = (m_addr + 4) % (1 << ADDR_W);
            end
            if (acc) begin
                if (model_legal(in_fmt, in_opcode))
                    q.push_back(model_enc(in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt,
                                          in_funct, in_imm16, in_jmp_target));
                else
                    m_err = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned fmt, op, rs, rt, rd, sh, fn, imm, tgt);
        in_fmt = 2'(fmt); in_opcode = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt);
        in_rd = 5'(rd); in_shamt = 5'(sh); in_funct = 6'(fn);
        in_imm16 = 16'(imm); in_jmp_target = 26'(tgt);
        in_valid = 1;
    endtask

    task automatic wait_acc();
        bit ok;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok = in_ready;
            step();
            if (ok) begin
                in_valid = 0;
                return;
            end
        end
        chk("accept_timeout", 32'(in_valid), 32'(0));
        in_valid = 0;
    endtask

    task automatic send(input int unsigned fmt, op, rs, rt, rd, sh, fn, imm, tgt);
        drive(fmt, op, rs, rt, rd, sh, fn, imm, tgt);
        wait_acc();
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        step();
        step();
        rst = 0;

        // R tuple, visible next cycle at BASE
        send(0, 0, 1, 2, 3, 0, 'h21, 0, 0);
        @(negedge clk);
        chk("tp_r_inst", out_inst, 32'h00221821);
        chk("tp_r_valid", 32'(out_valid), 32'd1);
        chk("tp_r_addr", 32'(out_addr), 32'h0);
        step();

        // I then J with the consumer always ready
        do_reset();
        out_ready = 1;
        send(1, 9, 1, 2, 0, 0, 0, 'h1234, 0);
        @(negedge clk);
        chk("tp_i_inst", out_inst, 32'h24221234);
        chk("tp_i_addr", 32'(out_addr), 32'h0);
        step();
        send(2, 2, 0, 0, 0, 0, 0, 0, 'h0100000);
        @(negedge clk);
        chk("tp_j_inst", out_inst, 32'h08100000);
        chk("tp_j_addr", 32'(out_addr), 32'h4);
        step();

        // Fill to DEPTH, offer one more, then drain
        do_reset();
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) send(0, 0, i, i + 1, i + 2, i, 'h20 + i, 0, 0);
        drive(1, 8, 7, 7, 0, 0, 0, 'hBEEF, 0);
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("full_count", 32'(count), 32'(DEPTH));
            step();
        end
        out_ready = 1;
        wait_acc();
        repeat (DEPTH + 2) step();

        // fmt=3 between two legal tuples
        do_reset();
        out_ready = 0;
        send(0, 0, 1, 2, 3, 0, 'h21, 0, 0);
        send(3, 5, 1, 1, 1, 1, 1, 1, 1);
        send(1, 9, 1, 2, 0, 0, 0, 'h1234, 0);
        @(negedge clk);
        chk("drop_err", 32'(err), 32'd1);
        chk("drop_count", 32'(count), 32'd2);
        step();
        out_ready = 1;
        repeat (4) step();
        @(negedge clk);
        chk("drop_err_sticky", 32'(err), 32'd1);
        chk("drop_addr", 32'(out_addr), 32'h8);
        step();

        // R tuple with non-zero opcode
        do_reset();
        out_ready = 0;
        send(0, 4, 1, 2, 3, 0, 'h21, 0, 0);
        @(negedge clk);
`ifdef INST_ENC_CHECK_EN
        chk("chk_err", 32'(err), 32'd1);
        chk("chk_count", 32'(count), 32'd0);
`else
        chk("nochk_inst", out_inst, 32'h10221821);
        chk("nochk_err", 32'(err), 32'd0);
`endif
        step();

        // Reset with three entries queued
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 3; i++) send(1, i, i, i, 0, 0, 0, i * 17, 0);
        do_reset();
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'(BASE));
        step();

        // Address wrap 0xC -> 0x0
        for (int i = 0; i < 4; i++) send(2, 3, 0, 0, 0, 0, 0, 0, i * 1000);
        out_ready = 1;
        repeat (4) step();
        out_ready = 0;
        send(1, 1, 1, 1, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("wrap_addr", 32'(out_addr), 32'h0);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 199) == 0;
            in_valid = $urandom_range(0, 2) != 0;
            in_fmt = 2'($urandom_range(0, 3));
            in_opcode = ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_shamt = 5'($urandom); in_funct = 6'($urandom);
            in_imm16 = 16'($urandom); in_jmp_target = 26'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            step();
        end
        rst = 0;
        in_valid = 0;
        out_ready = 1;
        repeat (10) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the instruction field decoder: packs MIPS fields (R/I/J format) into 32-bit instruction words.
- Buffers encoded words in a small FIFO and presents each with a sequential word address, for writing into instruction memory.
- Sits between the bench or boot program source and the instruction memory write port.
- Valid/ready handshake on both sides.

Parameters:
- DEPTH, 4: output FIFO entries; power of two, 2..16.
- ADDR_W, 32: width of out_addr.
- BASE_ADDR, 32'h0000_0000: first address emitted after reset; must be word aligned.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  field tuple present.
- in_ready  output  1  block can accept a tuple this cycle.
- in_fmt  input  2  0=R, 1=I, 2=J, 3=reserved.
- in_opcode  input  6  bits [31:26].
- in_rs  input  5  bits [25:21] (R/I).
- in_rt  input  5  bits [20:16] (R/I).
- in_rd  input  5  bits [15:11] (R).
- in_shamt  input  5  bits [10:6] (R).
- in_funct  input  6  bits [5:0] (R).
- in_imm16  input  16  bits [15:0] (I).
- in_jmp_target  input  26  bits [25:0] (J).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes head this cycle.
- out_inst  output  32  encoded word at FIFO head.
- out_addr  output  ADDR_W  byte address for out_inst.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- err  output  1  sticky: an illegal tuple was dropped.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - out_valid=0, count=0, err=0, out_inst=0.
  - out_addr=BASE_ADDR.
  - FIFO pointers cleared; any in-flight entries are discarded.
  - rst overrides same-cycle push and pop.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - in_ready = (count != DEPTH), from registered state only; no combinational path from out_ready.
- Encoding (pure concatenation, no sign extension):
  - R: {opcode, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, imm16}.
  - J: {opcode, jmp_target}.
- fmt=3: the tuple is accepted (handshake completes), not written, and sets err=1. err clears only on rst.
- Latency: an accepted legal tuple is visible at out_inst/out_valid on the next cycle if the FIFO was empty. Otherwise it queues in order behind earlier entries.
- out_inst and out_valid come from registered FIFO storage. out_inst holds its value while out_valid && !out_ready.
- Address counter:
  - out_addr always reflects the head entry's address.
  - Increments by 4 on each pop, regardless of fmt.
  - Wraps modulo 2^ADDR_W.
  - Dropped tuples consume no address.
- Occupancy:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged, at any occupancy 1..DEPTH-1.
  - Full: in_ready=0; a pop that cycle frees a slot visible next cycle.
  - Empty: out_valid=0; out_ready is ignored; out_addr holds.
- FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: INST_ENC_CHECK_EN.
- Defined: R-format tuples with in_opcode != 0 are treated as illegal (accepted, dropped, err=1). J-format tuples with in_opcode not in {2,3} are also treated as illegal.
- Not defined: only fmt=3 is illegal; all other tuples are encoded as given.

Test Plan:
- After reset, R-format tuple rs=1, rt=2, rd=3, shamt=0, funct=0x21, opcode=0 -> next cycle out_valid=1, out_inst=0x00221821, out_addr=0x0.
- I-format opcode=9, rs=1, rt=2, imm16=0x1234, then J-format opcode=2, target=0x0100000, with out_ready=1 -> out_inst 0x24221234 at addr 0x0, then 0x08100000 at addr 0x4.
- out_ready=0 with DEPTH+1 tuples offered -> in_ready drops after DEPTH accepts and count=DEPTH. Then out_ready=1 drains all DEPTH words in order at addrs 0,4,8,12.
- fmt=3 tuple between two legal tuples -> err=1 sticky, exactly two words emitted at consecutive addresses 0x0, 0x4.
- With INST_ENC_CHECK_EN defined, R tuple with opcode=0x04 -> dropped, err=1. Without the macro, the same tuple gives out_inst=0x10221821.
- Assert rst with 3 entries queued and ADDR_W=4 -> next cycle count=0, out_valid=0, out_addr=BASE_ADDR. Separately, 4 pops from addr 0xC -> addr wraps 0xC→0x0.
